// File: rtl/mux_arbiter4.sv
// Four-requester round-robin arbiter driving a 4:1 data mux, with bursts bounded by a beat
// limit, by the requester's last flag, or by the requester withdrawing.
module mux_arbiter4 #(
   parameter int unsigned DW        = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] data,
   input  logic [3:0]      last,
   input  logic            out_ready,
   output logic [3:0]      gnt,
   output logic [1:0]      sel,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic            out_last,
   output logic            busy
);

   localparam logic [3:0] MaxCnt = 4'(MAX_BURST);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  count_q, count_d;

   logic [DW-1:0] lanes [4];
   logic [1:0]    lane_sel;
   logic          cur_req, cur_last, beat, burst_end;
   logic [3:0]    count_inc;

   // Nearest set bit after p wins; p itself is checked last.
   function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
      logic [1:0] idx;
      rr_pick = p;
      for (int i = 4; i >= 1; i--) begin
         idx = p + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      for (int k = 0; k < 4; k++) lanes[k] = data[k*DW +: DW];
   end

   assign busy      = (state_q == StGrant);
   assign sel       = sel_q;
   assign gnt       = busy ? (4'b0001 << sel_q) : 4'b0000;
   assign lane_sel  = rst_n ? sel_q : 2'd0;
   assign out_data  = lanes[lane_sel];
   assign cur_req   = req[sel_q];
   assign cur_last  = last[sel_q];
   assign out_valid = rst_n & busy & cur_req;
   assign out_last  = rst_n & busy & cur_last;
   assign beat      = out_valid & out_ready;
   assign count_inc = count_q + 4'd1;
   assign burst_end = busy & (~cur_req | (beat & (cur_last | (count_inc == MaxCnt))));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               sel_d   = rr_pick(ptr_q, req);
               count_d = 4'd0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (beat) count_d = count_inc;
            if (burst_end) begin
               ptr_d   = sel_q;
               count_d = 4'd0;
               // Zero-bubble handover: the new owner is chosen against the just-ended owner.
               if (|req) sel_d = rr_pick(sel_q, req);
               else      state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Bench for mux_arbiter4: directed scenarios plus random traffic, all compared against a
// transaction-level round-robin model.
module tb_mux_arbiter4;

   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      req;
   logic [4*DW-1:0] data;
   logic [3:0]      last;
   logic            out_ready;
   logic [3:0]      gnt;
   logic [1:0]      sel;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            busy;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: owner (-1 when idle), last granted index, beats in current burst.
   int m_owner = -1;
   int m_ptr   = 3;
   int m_cnt   = 0;
   bit m_known = 1'b0;

   mux_arbiter4 #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
      .last      (last),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [DW-1:0] lane(input int k);
      return data[k*DW +: DW];
   endfunction

   function automatic int pick(input int p, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic check_outputs();
      check("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      if (!rst_n) begin
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_last", 32'(out_last), 32'd0);
         check("rst_data", 32'(out_data), 32'(lane(0)));
      end else if (m_owner >= 0) begin
         check("sel", 32'(sel), 32'(m_owner));
         check("out_valid", 32'(out_valid), 32'(req[m_owner]));
         check("out_last", 32'(out_last), 32'(last[m_owner]));
         check("out_data", 32'(out_data), 32'(lane(m_owner)));
      end
   endtask

   task automatic model_step();
      bit beat, done;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 3; m_cnt = 0; m_known = 1'b1;
         return;
      end
      if (!m_known) return;
      if (m_owner < 0) begin
         if (req != 4'b0) begin
            m_owner = pick(m_ptr, req);
            m_cnt   = 0;
         end
      end else begin
         beat = req[m_owner] && out_ready;
         if (beat) m_cnt++;
         done = !req[m_owner] || (beat && (last[m_owner] || m_cnt == MAX_BURST));
         if (done) begin
            m_ptr   = m_owner;
            m_cnt   = 0;
            m_owner = (req != 4'b0) ? pick(m_ptr, req) : -1;
         end
      end
   endtask

   // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
   task automatic cycle();
      #1;
      if (m_known) check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0; last = 4'b0; out_ready = 1'b1;
      data = {$urandom, $urandom} & {(4*DW){1'b1}};
      @(posedge clk);
      #1;
      do_reset();
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_sel", 32'(sel), 32'd0);

      // Single-beat transfer from requester 0.
      req = 4'b0001; last = 4'b0001; out_ready = 1'b1; data[DW-1:0] = 8'hA5;
      cycle();
      check("s1_gnt", 32'(gnt), 32'h1);
      check("s1_sel", 32'(sel), 32'h0);
      check("s1_data", 32'(out_data), 32'hA5);
      check("s1_last", 32'(out_last), 32'h1);
      cycle();
      req = 4'b0000;
      cycle();
      check("s1_idle", 32'(busy), 32'h0);

      // All requesting: 0,1,2,3,0 with 4 beats each, no gaps.
      do_reset();
      req = 4'b1111; last = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("rr_order", 32'(gnt), 32'd1 << ((i / 4) % 4));
      end

      // Stall on requester 2, then resume; early count drift would hand over early.
      do_reset();
      req = 4'b0100; out_ready = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_sel", 32'(sel), 32'h2);
         check("stall_busy", 32'(busy), 32'h1);
      end
      out_ready = 1'b1; req = 4'b0110;
      for (int i = 0; i < 4; i++) cycle();
      check("stall_handover", 32'(gnt), 32'h2);

      // Requester 1 withdraws after 2 beats.
      do_reset();
      req = 4'b0010;
      cycle();
      req = 4'b0110;
      cycle();
      cycle();
      req = 4'b0100;
      cycle();
      check("withdraw_gnt", 32'(gnt), 32'h4);
      req = 4'b1111;
      for (int i = 0; i < 6; i++) cycle();

      // Sole requester 3 re-granted back-to-back.
      do_reset();
      req = 4'b1000;
      for (int i = 0; i < 9; i++) begin
         cycle();
         check("regrant3", 32'(gnt), 32'h8);
      end

      // Reset in the middle of a burst.
      do_reset();
      req = 4'b0100;
      cycle();
      cycle();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'h0);
      cycle();
      check("midrst_gnt", 32'(gnt), 32'h0);
      rst_n = 1'b1; req = 4'b0110;
      cycle();
      check("midrst_first", 32'(gnt), 32'h2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(99) != 0);
         req       = 4'($urandom);
         last      = {($urandom_range(3) == 0), ($urandom_range(3) == 0),
                      ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
         out_ready = ($urandom_range(3) != 0);
         data      = {$urandom, $urandom} & {(4*DW){1'b1}};
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_arbiter4.md
MUX_ARBITER4 -- requirements
Module: mux_arbiter4

Interface
REQ-001 The block SHALL take parameter DW, default 8, as the data width of each requester lane and of the output.
REQ-002 The block SHALL take parameter MAX_BURST, default 4, as the maximum number of beats per grant (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, 4 bits: request from requester k on bit k.
REQ-006 The block SHALL have port data, input, 4*DW bits: lane k in bits [k*DW +: DW].
REQ-007 The block SHALL have port last, input, 4 bits: end-of-transfer flag of requester k, qualified by a beat.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream sink accepts a beat.
REQ-009 The block SHALL have port gnt, output, 4 bits: one-hot grant, all zero when idle.
REQ-010 The block SHALL have port sel, output, 2 bits: 4:1 mux select, equal to the index of the granted requester.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a beat is offered downstream.
REQ-012 The block SHALL have port out_data, output, DW bits: muxed data lane.
REQ-013 The block SHALL have port out_last, output, 1 bit: muxed last flag.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-015 The block SHALL implement two states: IDLE and GRANT.
REQ-016 In IDLE with req nonzero, the block SHALL register a winner and enter GRANT on the next edge, with gnt/sel valid 1 cycle after req is first seen.
REQ-017 The block SHALL pick the winner by round-robin: search ptr+1, ptr+2, ptr+3, ptr (mod 4), taking the first set req bit; ptr is the index of the last granted requester.
REQ-018 The block SHALL use 3 as the reset value of ptr, so that requester 0 has first priority after reset.
REQ-019 In GRANT, out_data SHALL equal lane sel, out_last SHALL equal last[sel], and out_valid SHALL equal req[sel], all combinational from the registered sel.
REQ-020 A beat SHALL occur when out_valid and out_ready are both 1; a beat SHALL increment the 4-bit beat counter, which clears on every new grant.
REQ-021 The burst SHALL end on any of: a beat with last[sel]=1; the beat that makes the count equal MAX_BURST; or req[sel]=0 in GRANT (requester withdrew, no beat).
REQ-022 At burst end, ptr SHALL load sel.
REQ-023 At burst end, if any req is set, the block SHALL re-arbitrate in the same cycle and hold GRANT with the new gnt/sel on the next edge (zero-bubble handover); otherwise it SHALL return to IDLE.
REQ-024 The current owner SHALL win re-arbitration only if it is the sole requester.
REQ-025 out_ready=0 SHALL stall: sel, gnt and count hold, and out_data tracks lane sel.
REQ-026 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-027 gnt SHALL always be one-hot or zero, and gnt SHALL equal (1 << sel) whenever busy=1.
REQ-028 With MAX_BURST=1, every beat SHALL end the burst.

Reset
REQ-029 On a clock edge with rst_n=0, the block SHALL set state=IDLE, gnt=0000, sel=00, count=0, ptr=3, busy=0.
REQ-030 During reset, out_valid=0 and out_last=0 SHALL hold, and out_data SHALL be lane 0.
REQ-031 rst_n asserted mid-burst SHALL abort the burst with no further beats, and the first grant after release SHALL follow the reset ptr.
REQ-032 Reset SHALL take priority over all other inputs on the same edge.

Verification
REQ-033 The bench SHALL cover: reset, then req=0001, last=0001, out_ready=1, lane0=8'hA5 -> gnt=0001 and sel=00 one cycle later, one beat with out_data=A5 and out_last=1, then IDLE.
REQ-034 The bench SHALL cover: req=1111 held, all last=0, out_ready=1 -> grant order 0,1,2,3,0, each grant exactly 4 beats, no idle cycle between grants.
REQ-035 The bench SHALL cover: requester 2 granted, out_ready=0 for 3 cycles -> sel=10, count held at 0 and busy=1; then out_ready=1 -> beats resume.
REQ-036 The bench SHALL cover: requester 1 granted, req[1] dropped after 2 beats while req=0100 -> next edge gnt=0100, and ptr=1 is recorded.
REQ-037 The bench SHALL cover: req=1000 only, last=0 -> requester 3 is re-granted back-to-back after 4 beats.
REQ-038 The bench SHALL cover: rst_n=0 during a beat of requester 2 -> next edge gnt=0000 and out_valid=0; after release with req=0110 -> requester 1 is granted first.
